// File: rtl/uart_rx_mmio.sv
// UART receiver with an MMIO read port; define UART_RX_FIFO_EN for a
// FIFO_DEPTH-byte receive FIFO, otherwise a single holding register.
module uart_rx_mmio #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rxd,
  input  logic        io_sel,
  input  logic        io_rstrb,
  output logic [31:0] io_rdata,
  output logic        rx_avail
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF_LD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  if (DIV < 4 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_rx_mmio: bad DIV or FIFO_DEPTH");
  end

  logic          s1, s2;
  logic [1:0]    sync_vld;
  logic          armed;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          expired;
  logic          push, fe_set;
  logic          pop, empty, ovr_set;
  logic          ovr, ferr;
  logic [7:0]    head;

  assign expired = (cnt == '0);
  assign push    = (state == STOP) && expired && s2;
  assign fe_set  = (state == STOP) && expired && !s2;
  assign pop     = io_sel & io_rstrb;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      s1       <= rxd;
      s2       <= s1;
      sync_vld <= {sync_vld[0], 1'b1};
      // only a genuinely sampled high line can precede a start edge
      armed    <= sync_vld[1] & s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
      shreg <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (armed && !s2) begin
            state <= START;
            cnt   <= HALF_LD;
          end
        end
        START: begin
          if (!expired) begin
            cnt <= cnt - CW'(1);
          end else if (!s2) begin
            state <= DATA;
            cnt   <= FULL_LD;
            idx   <= 3'd0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (!expired) begin
            cnt <= cnt - CW'(1);
          end else begin
            shreg <= {s2, shreg[7:1]};
            cnt   <= FULL_LD;
            idx   <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (!expired) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic        full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign ovr_set = push & full & ~pop;
  assign head    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end
`else
  logic [7:0] hold;
  logic       full, do_push, do_pop;

  assign empty   = ~full;
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & full;
  assign ovr_set = push & full & ~pop;
  assign head    = hold;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold <= 8'h00;
      full <= 1'b0;
    end else begin
      if (do_push) hold <= shreg;
      full <= do_push | (full & ~do_pop);
    end
  end
`endif

  assign rx_avail = ~empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ovr      <= 1'b0;
      ferr     <= 1'b0;
      io_rdata <= 32'h0;
    end else begin
      // flags are cleared by the read that reports them
      ovr  <= ovr_set | (ovr & ~pop);
      ferr <= fe_set | (ferr & ~pop);
      if (pop) begin
        io_rdata <= {21'h0, ferr, ovr, ~empty,
                     empty ? 8'h00 : head};
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio; a queue-based model of the
// receive buffer predicts every read word.
module tb_uart_rx_mmio;

  localparam int DIV = 10;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rxd = 1'b1;
  logic        io_sel = 1'b0;
  logic        io_rstrb = 1'b0;
  logic [31:0] io_rdata;
  logic        rx_avail;

  int checks = 0;
  int failures = 0;

  bit [7:0] q[$];
  bit m_ovr = 1'b0;
  bit m_ferr = 1'b0;

  uart_rx_mmio #(
    .CLK_FREQ_HZ(1000000),
    .BAUD_RATE  (100000),
    .FIFO_DEPTH (8)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .rxd     (rxd),
    .io_sel  (io_sel),
    .io_rstrb(io_rstrb),
    .io_rdata(io_rdata),
    .rx_avail(rx_avail)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic send_frame(input bit [7:0] b, input bit stop_ok);
    rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(DIV);
    end
    rxd = stop_ok;
    tick(DIV);
    if (!stop_ok) begin
      rxd = 1'b1;
      tick(DIV);
      m_ferr = 1'b1;
    end else if (q.size() < DEPTH) begin
      q.push_back(b);
    end else begin
      m_ovr = 1'b1;
    end
    tick(2);
  endtask

  task automatic do_read(output logic [31:0] d);
    io_sel = 1'b1;
    io_rstrb = 1'b1;
    tick();
    io_sel = 1'b0;
    io_rstrb = 1'b0;
    d = io_rdata;
  endtask

  task automatic model_read(output logic [31:0] e);
    e = 32'h0;
    e[10] = m_ferr;
    e[9] = m_ovr;
    if (q.size() != 0) begin
      e[8] = 1'b1;
      e[7:0] = q.pop_front();
    end
    m_ovr = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    rxd = 1'b1;
    tick(3);
    resetn = 1'b1;
    model_clear();
    tick(3);
    checks++;
    if (io_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=%h", io_rdata, 32'h0);
    end
    checks++;
    if (rx_avail !== 1'b0) begin
      failures++;
      $display("FAIL reset_avail got=%b exp=0", rx_avail);
    end
  endtask

  task automatic test_single();
    int n;
    logic [31:0] d, e;
    n = 0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        while (rx_avail !== 1'b1 && n < 150) begin
          tick();
          n++;
        end
      end
    join
    checks++;
    if (n < 90 || n > 105) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=90..105", n);
    end
    do_read(d);
    model_read(e);
    checks++;
    if (d !== 32'h155 || d !== e) begin
      failures++;
      $display("FAIL single_read got=%h exp=%h", d, 32'h155);
    end
    checks++;
    if (rx_avail !== 1'b0) begin
      failures++;
      $display("FAIL single_avail got=%b exp=0", rx_avail);
    end
  endtask

  task automatic test_empty_read();
    logic [31:0] d;
    do_read(d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL empty_read got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(30);
    checks++;
    if (rx_avail !== 1'b0) begin
      failures++;
      $display("FAIL glitch_avail got=%b exp=0", rx_avail);
    end
    do_read(d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL glitch_read got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_ferr();
    logic [31:0] d, e;
    send_frame(8'h41, 1'b0);
    checks++;
    if (rx_avail !== 1'b0) begin
      failures++;
      $display("FAIL ferr_avail got=%b exp=0", rx_avail);
    end
    do_read(d);
    model_read(e);
    checks++;
    if (d !== 32'h400 || d !== e) begin
      failures++;
      $display("FAIL ferr_read1 got=%h exp=%h", d, 32'h400);
    end
    do_read(d);
    model_read(e);
    checks++;
    if (d !== 32'h0 || d !== e) begin
      failures++;
      $display("FAIL ferr_read2 got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] d, e;
    for (int i = 0; i <= DEPTH; i++)
      send_frame(8'h61 + 8'(i), 1'b1);
    checks++;
    if (rx_avail !== 1'b1) begin
      failures++;
      $display("FAIL ovr_avail got=%b exp=1", rx_avail);
    end
    for (int i = 0; i <= DEPTH; i++) begin
      do_read(d);
      model_read(e);
      checks++;
      if (d !== e) begin
        failures++;
        $display("FAIL ovr_read%0d got=%h exp=%h", i, d, e);
      end
      if (i == 0) begin
        checks++;
        if (d !== 32'h361) begin
          failures++;
          $display("FAIL ovr_first got=%h exp=%h", d, 32'h361);
        end
      end
    end
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL ovr_last got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_reset_mid();
    bit [7:0] b;
    logic [31:0] d, e;
    b = 8'h7E;
    rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < 7; i++) begin
      rxd = b[i];
      tick(DIV);
    end
    rxd = b[7];
    tick();
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    model_clear();
    tick(DIV - 3);
    rxd = 1'b1;
    tick(DIV + 5);
    send_frame(8'h31, 1'b1);
    do_read(d);
    model_read(e);
    checks++;
    if (d !== 32'h131 || d !== e) begin
      failures++;
      $display("FAIL rstmid_read1 got=%h exp=%h", d, 32'h131);
    end
    do_read(d);
    model_read(e);
    checks++;
    if (d !== 32'h0 || d !== e) begin
      failures++;
      $display("FAIL rstmid_read2 got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    bit [7:0] b;
    bit ok;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      ok = ($urandom_range(5) != 0);
      send_frame(b, ok);
      tick($urandom_range(4));
      if ($urandom_range(1) == 1) begin
        do_read(d);
        model_read(e);
        checks++;
        if (d !== e) begin
          failures++;
          $display("FAIL rand_read%0d got=%h exp=%h", i, d, e);
        end
      end
      checks++;
      if (rx_avail !== (q.size() != 0)) begin
        failures++;
        $display("FAIL rand_avail%0d got=%b exp=%b",
                 i, rx_avail, q.size() != 0);
      end
    end
    for (int i = 0; i <= DEPTH; i++) begin
      do_read(d);
      model_read(e);
      checks++;
      if (d !== e) begin
        failures++;
        $display("FAIL rand_drain%0d got=%h exp=%h", i, d, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_empty_read();
    test_glitch();
    test_ferr();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_mmio.md
UART_RX_MMIO -- requirements
Module: uart_rx_mmio

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 50000000, clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, serial bit rate; DIV = CLK_FREQ_HZ/BAUD_RATE (integer, truncated), DIV >= 4.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, power of two >= 2, used only with UART_RX_FIFO_EN.
REQ-004 The block SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-005 The block SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port rxd  input  1  asynchronous serial line, idle high.
REQ-007 The block SHALL have port io_sel  input  1  IO page decode hit for the RX data word (isIO & word-address bit).
REQ-008 The block SHALL have port io_rstrb  input  1  CPU read strobe; a read occurs when io_sel & io_rstrb.
REQ-009 The block SHALL have port io_rdata  output  32  registered read data.
REQ-010 The block SHALL have port rx_avail  output  1  high while at least one byte is buffered.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer before any use; only the synchronized value is sampled.
REQ-012 The receiver FSM SHALL have states IDLE, START, DATA, STOP, with a baud counter and 3-bit bit index.
REQ-013 IDLE->START on a synchronized high-to-low transition; counter loaded for DIV/2 cycles.
REQ-014 START, counter expiry: line low -> DATA, counter = DIV; line high -> false start, back to IDLE, nothing stored.
REQ-015 DATA: 8 samples at DIV-cycle intervals, LSB first, shifted into the byte; after bit 7 -> STOP.
REQ-016 STOP, DIV cycles later: line high -> push byte, IDLE; line low -> discard byte, set sticky ferr, IDLE after line returns high.
REQ-017 A read (io_sel & io_rstrb) SHALL update io_rdata on the next clk edge, 1-cycle latency, matching RAM read timing.
REQ-018 io_rdata format: [7:0] byte, [8] valid, [9] overrun, [10] ferr, [31:11] zero.
REQ-019 Read with a byte buffered: valid=1, oldest byte returned and popped.
REQ-020 Read with buffer empty: valid=0, [7:0]=0, no state change except flag clear.
REQ-021 overrun and ferr SHALL be reported then cleared by the same read; an event coinciding with that read sets the flag again.
REQ-022 Push while buffer full SHALL drop the new byte and set overrun; buffered bytes are unaltered.
REQ-023 Push and pop in the same cycle SHALL both take effect, including when full (no overrun) and when empty (the pop returns valid=0, the pushed byte remains).
REQ-024 io_rdata SHALL hold its value when no read occurs; rx_avail is combinational from buffer occupancy.

Reset
REQ-025 When resetn is low at a clk edge: FSM->IDLE, counters 0, buffer empty, overrun=0, ferr=0, io_rdata=0, synchronizer flops=1.
REQ-026 Reset mid-frame SHALL abandon the frame; the next start bit is detected only after rxd is seen high.

Configuration
REQ-027 With macro UART_RX_FIFO_EN defined, the buffer SHALL be a FIFO of FIFO_DEPTH bytes with wrapping read/write pointers and a count of log2(FIFO_DEPTH)+1 bits.
REQ-028 Without UART_RX_FIFO_EN, the buffer SHALL be a single holding register plus a full flag, with identical overrun and same-cycle rules (depth 1).

Verification (bench: CLK_FREQ_HZ=1000000, BAUD_RATE=100000, DIV=10)
REQ-029 Reset, then send 0x55 -> rx_avail=1 about 95 cycles after the start edge; a read returns io_rdata=0x00000155, then rx_avail=0.
REQ-030 Read with the buffer empty -> io_rdata=0x00000000 one cycle after the strobe.
REQ-031 Low glitch of 3 cycles on rxd -> no byte; rx_avail stays 0.
REQ-032 Send 0x41 with a low stop bit -> no byte; the next read returns 0x00000400, the following read 0x00000000.
REQ-033 FIFO_EN: send 9 bytes 0x61..0x69 without reading -> reads return 0x161..0x168, the first read with bit9 set (0x361), the ninth read returns 0x00000000; without FIFO_EN send 2 bytes -> first read returns 0x00000361.
REQ-034 Assert resetn low during DATA of 0x7E, then send 0x31 -> only 0x131 is received.
